// File: rtl/trng_byte_collector_if.sv
// trng_byte_collector_if
//   Bundles the raw-entropy input stream, the byte output stream and the
//   status flags of trng_byte_collector.
//
//   Signals
//     enable      : collection gate (low clears partial collection state)
//     raw_bit     : raw ring-oscillator entropy bit
//     raw_valid   : qualifies raw_bit
//     rd_data     : FIFO head byte (8'h00 when empty)
//     rd_valid    : FIFO non-empty
//     rd_ready    : consumer ready
//     fifo_level  : FIFO occupancy, $clog2(FIFO_DEPTH)+1 bits
//     health_fail : sticky repetition-count failure
//     overflow    : sticky dropped-byte flag
//
//   Handshake: a raw bit is accepted on a rising edge where enable=1 and
//   raw_valid=1. A byte is popped on a rising edge where rd_valid=1 and
//   rd_ready=1; rd_data holds its value while rd_valid=1 and rd_ready=0.
//
//   Modports
//     master : entropy source plus byte consumer
//     slave  : the collector
interface trng_byte_collector_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          enable;
  logic          raw_bit;
  logic          raw_valid;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [LW-1:0] fifo_level;
  logic          health_fail;
  logic          overflow;

  modport master (
    output enable, raw_bit, raw_valid, rd_ready,
    input  rd_data, rd_valid, fifo_level, health_fail, overflow
  );

  modport slave (
    input  enable, raw_bit, raw_valid, rd_ready,
    output rd_data, rd_valid, fifo_level, health_fail, overflow
  );
endinterface

// File: rtl/trng_byte_collector.sv
// trng_byte_collector
//   Von Neumann debiaser, LSB-first byte packer, repetition-count health
//   test and a small output byte FIFO for a ring-oscillator TRNG.
//
//   Parameters
//     FIFO_DEPTH : output FIFO depth in bytes (power of two, >= 2)
//     RCT_CUTOFF : repetition-count cutoff in raw bits (2..255)
//
//   Ports
//     CLK  : clock, all state updates on the rising edge
//     RSTn : asynchronous active-low reset
//     bus  : trng_byte_collector_if slave modport (raw input stream,
//            byte output stream, fifo_level, health_fail, overflow)
module trng_byte_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  trng_byte_collector_if.slave  bus
);

  localparam int               AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]       CUT     = 8'(RCT_CUTOFF);

  // Collection state
  logic       pair_have;   // first bit of a pair is stored
  logic       pair_first;  // that first bit
  logic [7:0] byte_sr;     // partial byte, filled LSB-first
  logic [2:0] bit_cnt;     // debiased bits already in byte_sr
  logic [7:0] run_cnt;     // current run length, 0 = no previous bit
  logic       prev_bit;
  logic       health_fail_q;
  logic       overflow_q;

  // FIFO state; pointers carry one wrap bit so full and empty differ
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] level;

  logic       accept;
  logic       deb_valid;
  logic       byte_done;
  logic [7:0] full_byte;
  logic       full;
  logic       rd_valid_i;
  logic       pop;
  logic       push;
  logic [7:0] run_next;

  assign accept     = bus.enable & bus.raw_valid;
  // A pair completes when a first bit is already held; only 10/01 emit.
  assign deb_valid  = accept & pair_have & (pair_first != bus.raw_bit);
  assign byte_done  = deb_valid & (bit_cnt == 3'd7);
  // The emitted debiased bit equals the first bit of the pair.
  assign full_byte  = {pair_first, byte_sr[6:0]};

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == DEPTH_L);
  assign rd_valid_i = (level != '0);
  assign pop        = rd_valid_i & bus.rd_ready;
  // When full, a same-edge pop frees the slot being written.
  assign push       = byte_done & ~health_fail_q & (~full | pop);

  always_comb begin
    run_next = 8'd1;
    if (run_cnt != 8'd0 && bus.raw_bit == prev_bit) begin
      if (run_cnt == CUT) run_next = run_cnt;
      else                run_next = run_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pair_have     <= 1'b0;
      pair_first    <= 1'b0;
      byte_sr       <= 8'h00;
      bit_cnt       <= 3'd0;
      run_cnt       <= 8'd0;
      prev_bit      <= 1'b0;
      health_fail_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      if (!bus.enable) begin
        pair_have <= 1'b0;
        byte_sr   <= 8'h00;
        bit_cnt   <= 3'd0;
        run_cnt   <= 8'd0;
      end else if (bus.raw_valid) begin
        prev_bit <= bus.raw_bit;
        run_cnt  <= run_next;
        if (run_next == CUT) health_fail_q <= 1'b1;

        if (!pair_have) begin
          pair_have  <= 1'b1;
          pair_first <= bus.raw_bit;
        end else begin
          pair_have <= 1'b0;
          if (deb_valid) begin
            if (bit_cnt == 3'd7) byte_sr <= 8'h00;
            else                 byte_sr[bit_cnt] <= pair_first;
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (byte_done && !health_fail_q && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= full_byte;
  end

  assign bus.rd_data     = rd_valid_i ? mem[rd_ptr[AW-1:0]] : 8'h00;
  assign bus.rd_valid    = rd_valid_i;
  assign bus.fifo_level  = level;
  assign bus.health_fail = health_fail_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_trng_byte_collector.sv
module tb_trng_byte_collector;

  localparam int DEPTH = 4;
  localparam int CUT   = 16;

  // ---------------- clock / reset ----------------
  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  trng_byte_collector_if #(.FIFO_DEPTH(DEPTH)) bus();

  trng_byte_collector #(.FIFO_DEPTH(DEPTH), .RCT_CUTOFF(CUT)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // reference model state
  int m_level;
  int m_pend;     // -1 = no stored pair bit
  int m_run;
  int m_last;
  bit m_ovf;
  bit m_fail;
  bit db_q[$];    // debiased bits of the byte under construction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_level = 0; m_pend = -1; m_run = 0; m_last = 0;
    m_ovf = 0; m_fail = 0;
    db_q.delete();
    exp_q.delete();
  endtask

  // Predict what the next rising edge does, from the behavioural rules.
  task automatic model_edge(input logic en, input logic b, input logic v, input logic r);
    bit pop, byte_rdy, new_fail;
    logic [7:0] byt;
    int bi;
    bi = int'(b);
    pop = (m_level > 0) && r;
    byte_rdy = 0; new_fail = 0; byt = 8'h00;
    if (!en) begin
      m_pend = -1; db_q.delete(); m_run = 0;
    end else if (v) begin
      if (m_run == 0 || bi != m_last) m_run = 1;
      else if (m_run < CUT) m_run++;
      m_last = bi;
      if (m_run == CUT) new_fail = 1;
      if (m_pend < 0) m_pend = bi;
      else begin
        if (m_pend != bi) db_q.push_back(m_pend[0]);
        m_pend = -1;
      end
      if (db_q.size() == 8) begin
        for (int i = 0; i < 8; i++) byt = byt | (8'(db_q[i]) << i);
        byte_rdy = 1;
        db_q.delete();
      end
    end
    if (byte_rdy && !m_fail) begin
      if (m_level == DEPTH && !pop) m_ovf = 1;
      else begin
        exp_q.push_back(byt);
        m_level++;
      end
    end
    if (pop) m_level--;
    if (new_fail) m_fail = 1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RSTn && bus.rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected actual=0x%0h required=none at %0t", bus.rd_data, $time);
      end else begin
        check("rd_data", int'(bus.rd_data), int'(exp_q[0]));
        if (bus.rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; drives for the next edge, then checks.
  task automatic step(input logic en, input logic b, input logic v, input logic r);
    bus.enable = en; bus.raw_bit = b; bus.raw_valid = v; bus.rd_ready = r;
    model_edge(en, b, v, r);
    @(posedge CLK); #1;
    check("fifo_level",  int'(bus.fifo_level),  m_level);
    check("overflow",    int'(bus.overflow),    int'(m_ovf));
    check("health_fail", int'(bus.health_fail), int'(m_fail));
  endtask

  // Pair 10 carries a 1, pair 01 carries a 0; r_last applies to the final bit.
  task automatic send_byte(input logic [7:0] val, input logic r, input logic r_last);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, val[i], 1'b1, r);
      step(1'b1, ~val[i], 1'b1, (i == 7) ? r_last : r);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    bus.enable = 1'b0; bus.raw_bit = 1'b0; bus.raw_valid = 1'b0; bus.rd_ready = 1'b0;
    RSTn = 1'b0;
    #2;
    model_clear();
    check("rst_rd_valid",    int'(bus.rd_valid),    0);
    check("rst_rd_data",     int'(bus.rd_data),     0);
    check("rst_fifo_level",  int'(bus.fifo_level),  0);
    check("rst_health_fail", int'(bus.health_fail), 0);
    check("rst_overflow",    int'(bus.overflow),    0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    bus.enable = 1'b0; bus.raw_bit = 1'b0; bus.raw_valid = 1'b0; bus.rd_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;

    // Basic byte: pairs 10,01,10,10,01,01,01,10
    do_reset();
    v = 8'h8D;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, v[i], 1'b1, 1'b0);
      if (i == 7) check("pre_rd_valid", int'(bus.rd_valid), 0);
      step(1'b1, ~v[i], 1'b1, 1'b0);
    end
    check("basic_rd_valid", int'(bus.rd_valid), 1);
    check("basic_rd_data",  int'(bus.rd_data),  8'h8D);
    check("basic_level",    int'(bus.fifo_level), 1);
    drain(2);

    // Same byte with 00 / 11 pairs interleaved
    for (int i = 0; i < 8; i++) begin
      step(1'b1, v[i], 1'b1, 1'b0);
      step(1'b1, ~v[i], 1'b1, 1'b0);
      if (i < 7) begin
        step(1'b1, i[0], 1'b1, 1'b0);
        step(1'b1, i[0], 1'b1, 1'b0);
      end
    end
    check("interleave_rd_data", int'(bus.rd_data), 8'h8D);
    check("interleave_level",   int'(bus.fifo_level), 1);
    drain(2);

    // Overflow: DEPTH+1 bytes with no consumer
    do_reset();
    for (int k = 0; k <= DEPTH; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("ovf_flag",  int'(bus.overflow),   1);
    check("ovf_level", int'(bus.fifo_level), DEPTH);
    drain(DEPTH + 1);

    // Full push with a same-edge pop retains the 5th byte
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b1);
    check("fullpop_ovf",   int'(bus.overflow),   0);
    check("fullpop_level", int'(bus.fifo_level), DEPTH);
    drain(DEPTH + 1);

    // Health test: 16 identical bits
    do_reset();
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < CUT; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      if (i == CUT - 2) check("hf_before", int'(bus.health_fail), 0);
    end
    check("hf_set", int'(bus.health_fail), 1);
    send_byte(8'h5A, 1'b0, 1'b0);
    check("hf_no_push", int'(bus.fifo_level), 2);
    drain(4);
    check("hf_sticky", int'(bus.health_fail), 1);

    // Reset mid-byte discards partial data
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    do_reset();
    send_byte(8'h8D, 1'b0, 1'b0);
    check("rst_mid_rd_data", int'(bus.rd_data), 8'h8D);
    drain(2);

    // enable=0 mid-byte drops the partial byte
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h8D, 1'b0, 1'b0);
    check("en_clear_rd_data", int'(bus.rd_data), 8'h8D);
    check("en_clear_level",   int'(bus.fifo_level), 1);
    drain(2);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      step(($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0));
    end
    drain(DEPTH + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_byte_collector.md
TRNG_BYTE_COLLECTOR -- requirements
Module: trng_byte_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the output FIFO depth in bytes (power of two, minimum 2).
REQ-002 Parameter RCT_CUTOFF, default 16, SHALL set the repetition-count health-test cutoff in raw bits (range 2..255).
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RSTn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL gate collection; low means raw bits are ignored.
REQ-006 raw_bit  input  1  SHALL carry one raw ring-oscillator entropy bit (XOR-buffer tap).
REQ-007 raw_valid  input  1  SHALL qualify raw_bit; a bit is accepted on a rising edge where enable=1 and raw_valid=1.
REQ-008 rd_data  output  8  SHALL present the FIFO head byte.
REQ-009 rd_valid  output  1  SHALL be high when the FIFO is non-empty.
REQ-010 rd_ready  input  1  SHALL be the consumer ready; a pop occurs on an edge with rd_valid=1 and rd_ready=1.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  SHALL report the current FIFO occupancy.
REQ-012 health_fail  output  1  SHALL be the sticky repetition-count failure flag.
REQ-013 overflow  output  1  SHALL be the sticky dropped-byte flag.

Function
REQ-014 Debiasing SHALL be von Neumann on consecutive accepted raw bits, grouped in pairs: 1st bit stored, 2nd bit completes the pair.
REQ-015 Pair 10 SHALL yield debiased bit 1; pair 01 SHALL yield 0; pairs 00 and 11 SHALL yield nothing.
REQ-016 Debiased bits SHALL be packed LSB-first: the first bit of a byte goes to bit 0 and the eighth to bit 7.
REQ-017 The byte SHALL be written to the FIFO on the same edge that accepts the raw bit completing its 8th debiased bit.
REQ-018 rd_valid SHALL rise in the cycle following that write edge when the FIFO was empty; latency is 1 cycle from the completing edge.
REQ-019 FIFO ordering SHALL be first-in first-out; rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-020 Push while full without a pop on the same edge SHALL drop the byte, set overflow, and leave FIFO contents unchanged.
REQ-021 Push while full with a pop on the same edge SHALL succeed; fifo_level stays FIFO_DEPTH.
REQ-022 A simultaneous push and pop at any other level SHALL leave fifo_level unchanged.
REQ-023 Pop with the FIFO empty SHALL be impossible, because rd_valid=0.
REQ-024 The repetition counter SHALL be set to 1 on an accepted bit differing from the previous accepted bit (or on the first accepted bit), else incremented, saturating at RCT_CUTOFF.
REQ-025 health_fail SHALL set on the edge where the run count reaches RCT_CUTOFF.
REQ-026 health_fail SHALL then stay high until reset.
REQ-027 While health_fail=1, no further bytes SHALL be pushed; the FIFO SHALL continue to drain normally.
REQ-028 enable=0 SHALL clear the pending pair bit, the partial byte (bit count 0), and the run counter on the next edge.
REQ-029 enable=0 SHALL NOT alter FIFO contents, health_fail, or overflow.
REQ-030 raw_valid=0 with enable=1 SHALL hold all collection state unchanged.

Reset
REQ-031 RSTn=0 SHALL asynchronously clear the FIFO pointers, pair state, partial byte, bit count, run counter, health_fail, and overflow.
REQ-032 During reset: rd_valid=0, rd_data=8'h00, fifo_level=0, health_fail=0, overflow=0.
REQ-033 A reset mid-byte or mid-pair SHALL discard the partial data; collection restarts with a fresh pair after RSTn rises.
REQ-034 Reset release SHALL be synchronous to CLK; the first accepted bit is on the first rising edge after RSTn is high.

Verification
REQ-035 Raw pairs 10,01,10,10,01,01,01,10 with rd_ready=0 -> rd_valid=1 one cycle after the 16th bit, rd_data=8'h8D, fifo_level=1.
REQ-036 Raw pairs 00,11 interleaved between the REQ-035 pairs -> identical result of 8'h8D, no extra bytes.
REQ-037 rd_ready=0, push FIFO_DEPTH+1 bytes (4+1) -> fifo_level=4, overflow=1, the first 4 bytes read back in order.
REQ-038 Same as REQ-037, but with rd_ready=1 on the 5th byte's completing edge -> overflow=0, fifo_level=4, the 5th byte is retained.
REQ-039 16 consecutive accepted 1s -> health_fail=1 on the 16th edge; later valid pairs push nothing; the existing FIFO drains.
REQ-040 RSTn pulsed low after 11 raw bits, then REQ-035 stimulus -> rd_data=8'h8D and no stale bits.
